// File: rtl/sr_latch_driver_if.sv
// Command/response and latch-pin bundle for sr_latch_driver.
// slave = the driver block; master = the test/control logic and latch model.
interface sr_latch_driver_if;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       s_n;
  logic       r_n;
  logic       q;
  logic       qn;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_q;
  logic       rsp_qn;
  logic       rsp_err;
  logic       busy;
  logic [7:0] err_cnt;

  modport slave (
    input  cmd_valid, cmd, q, qn, rsp_ready,
    output cmd_ready, s_n, r_n, rsp_valid, rsp_q, rsp_qn, rsp_err, busy, err_cnt
  );

  modport master (
    output cmd_valid, cmd, q, qn, rsp_ready,
    input  cmd_ready, s_n, r_n, rsp_valid, rsp_q, rsp_qn, rsp_err, busy, err_cnt
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Drives timed active-low pulses into a NAND SR latch, samples q/qn back, and reports pass/fail.
// Latency PULSE_CYC+SETTLE_CYC+SYNC_STAGES (read: SETTLE_CYC+SYNC_STAGES); one command in flight, response held until accepted.
module sr_latch_driver #(
  parameter int PULSE_CYC   = 4,
  parameter int SETTLE_CYC  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  sr_latch_driver_if.slave bus
);

  localparam int SETTLE_TOT = SETTLE_CYC + SYNC_STAGES;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PULSE  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_SET   = 2'b01;
  localparam logic [1:0] CMD_RESET = 2'b10;

  logic [1:0]             state_q, state_d;
  logic [1:0]             cmd_q, cmd_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   s_n_q, s_n_d;
  logic                   r_n_q, r_n_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_q_q, rsp_q_d;
  logic                   rsp_qn_q, rsp_qn_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic [SYNC_STAGES-1:0] qs_q, qs_d;
  logic [SYNC_STAGES-1:0] qns_q, qns_d;

  logic q_sync, qn_sync, exp_err;

  assign q_sync  = qs_q[SYNC_STAGES-1];
  assign qn_sync = qns_q[SYNC_STAGES-1];

  // A read has no expected polarity; it only fails when the latch outputs agree.
  always_comb begin
    exp_err = 1'b0;
    case (cmd_q)
      CMD_READ:  exp_err = (q_sync == qn_sync);
      CMD_SET:   exp_err = ({q_sync, qn_sync} != 2'b10);
      CMD_RESET: exp_err = ({q_sync, qn_sync} != 2'b01);
      default:   exp_err = ({q_sync, qn_sync} != 2'b11);
    endcase
  end

  always_comb begin
    qs_d        = {qs_q[SYNC_STAGES-2:0], bus.q};
    qns_d       = {qns_q[SYNC_STAGES-2:0], bus.qn};
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    s_n_d       = s_n_q;
    r_n_d       = r_n_q;
    rsp_valid_d = rsp_valid_q;
    rsp_q_d     = rsp_q_q;
    rsp_qn_d    = rsp_qn_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d = bus.cmd;
          if (bus.cmd == CMD_READ) begin
            state_d = ST_SETTLE;
            cnt_d   = 16'(SETTLE_TOT - 1);
          end else begin
            state_d = ST_PULSE;
            cnt_d   = 16'(PULSE_CYC - 1);
            s_n_d   = ~bus.cmd[0];
            r_n_d   = ~bus.cmd[1];
          end
        end
      end
      ST_PULSE: begin
        if (cnt_q == 16'd0) begin
          state_d = ST_SETTLE;
          cnt_d   = 16'(SETTLE_TOT - 1);
          // "Both" keeps the latch forced through settle so the 11 state is sampled.
          if (cmd_q != 2'b11) begin
            s_n_d = 1'b1;
            r_n_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 16'd0) begin
          state_d     = ST_RESP;
          s_n_d       = 1'b1;
          r_n_d       = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_q_d     = q_sync;
          rsp_qn_d    = qn_sync;
          rsp_err_d   = exp_err;
          if (exp_err && (err_cnt_q != 8'hff)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 2'b00;
      cnt_q       <= 16'd0;
      s_n_q       <= 1'b1;
      r_n_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_q_q     <= 1'b0;
      rsp_qn_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= 8'd0;
      qs_q        <= '0;
      qns_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      s_n_q       <= s_n_d;
      r_n_q       <= r_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q_q     <= rsp_q_d;
      rsp_qn_q    <= rsp_qn_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
      qs_q        <= qs_d;
      qns_q       <= qns_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.s_n       = s_n_q;
  assign bus.r_n       = r_n_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_q     = rsp_q_q;
  assign bus.rsp_qn    = rsp_qn_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural NAND latch model on q/qn.
module tb_sr_latch_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stuck = 1'b0;
  logic lat_state = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sr_latch_driver_if bus();

  sr_latch_driver #(.PULSE_CYC(4), .SETTLE_CYC(2), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // NAND latch: low input forces its side; both low gives Q=Qn=1; release holds the last single-forced state.
  always @(bus.s_n or bus.r_n or stuck) begin
    if (!bus.s_n && bus.r_n) lat_state = 1'b1;
    if (bus.s_n && !bus.r_n) lat_state = 1'b0;
    if (stuck) begin
      bus.q  = 1'b0;
      bus.qn = 1'b1;
    end else if (!bus.s_n && !bus.r_n) begin
      bus.q  = 1'b1;
      bus.qn = 1'b1;
    end else begin
      bus.q  = lat_state;
      bus.qn = ~lat_state;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Issue one command from IDLE; report response latency and low-sample counts of s_n/r_n.
  task automatic run_cmd(input logic [1:0] c, output int lat, output int s_lo, output int r_lo);
    bit got = 0;
    lat = -1; s_lo = 0; r_lo = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (bus.rsp_valid) begin
        got = 1;
        lat = i;
      end
      if (!bus.s_n) s_lo++;
      if (!bus.r_n) r_lo++;
    end
    check("rsp_timeout", 32'(got), 32'd1);
  endtask

  task automatic ack_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  int lat, s_lo, r_lo;
  logic hq, hqn, he;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd       = 2'b00;
    bus.rsp_ready = 1'b0;
    #12;
    check("rst_s_n", 32'(bus.s_n), 32'd1);
    check("rst_r_n", 32'(bus.r_n), 32'd1);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    check("rst_rsp_q", 32'({bus.rsp_q, bus.rsp_qn, bus.rsp_err}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Set
    run_cmd(2'b01, lat, s_lo, r_lo);
    check("set_lat", 32'(lat), 32'd8);
    check("set_s_lo", 32'(s_lo), 32'd4);
    check("set_r_lo", 32'(r_lo), 32'd0);
    check("set_rsp", 32'({bus.rsp_q, bus.rsp_qn, bus.rsp_err}), 32'b100);
    check("set_busy", 32'(bus.busy), 32'd1);
    ack_rsp();
    check("set_ack_valid", 32'(bus.rsp_valid), 32'd0);
    check("set_ack_ready", 32'(bus.cmd_ready), 32'd1);

    // Reset
    run_cmd(2'b10, lat, s_lo, r_lo);
    check("rst_cmd_lat", 32'(lat), 32'd8);
    check("rst_cmd_r_lo", 32'(r_lo), 32'd4);
    check("rst_cmd_s_lo", 32'(s_lo), 32'd0);
    check("rst_cmd_rsp", 32'({bus.rsp_q, bus.rsp_qn, bus.rsp_err}), 32'b010);
    check("rst_cmd_err_cnt", 32'(bus.err_cnt), 32'd0);
    ack_rsp();

    // Both: held low through settle, released on the capture edge
    run_cmd(2'b11, lat, s_lo, r_lo);
    check("both_lat", 32'(lat), 32'd8);
    check("both_s_lo", 32'(s_lo), 32'd8);
    check("both_r_lo", 32'(r_lo), 32'd8);
    check("both_rsp", 32'({bus.rsp_q, bus.rsp_qn, bus.rsp_err}), 32'b110);
    check("both_released", 32'({bus.s_n, bus.r_n}), 32'b11);
    ack_rsp();

    // Read: no pulse, shorter latency; latch back to Q=0 after release
    run_cmd(2'b00, lat, s_lo, r_lo);
    check("read_lat", 32'(lat), 32'd4);
    check("read_pulses", 32'(s_lo + r_lo), 32'd0);
    check("read_rsp", 32'({bus.rsp_q, bus.rsp_qn, bus.rsp_err}), 32'b010);
    ack_rsp();

    // Stuck-at-0 latch: every set fails, counter saturates
    stuck = 1'b1;
    run_cmd(2'b01, lat, s_lo, r_lo);
    check("stuck_rsp", 32'({bus.rsp_q, bus.rsp_qn, bus.rsp_err}), 32'b011);
    check("stuck_err_cnt1", 32'(bus.err_cnt), 32'd1);
    ack_rsp();
    for (int n = 2; n <= 300; n++) begin
      run_cmd(2'b01, lat, s_lo, r_lo);
      if (n == 254) check("stuck_err_cnt254", 32'(bus.err_cnt), 32'd254);
      if (n == 255) check("stuck_err_cnt255", 32'(bus.err_cnt), 32'd255);
      ack_rsp();
    end
    check("stuck_err_cnt_sat", 32'(bus.err_cnt), 32'd255);
    stuck = 1'b0;

    // Response backpressure with a stray command during the hold
    run_cmd(2'b01, lat, s_lo, r_lo);
    hq = bus.rsp_q; hqn = bus.rsp_qn; he = bus.rsp_err;
    check("hold_first", 32'({hq, hqn, he}), 32'b100);
    for (int i = 0; i < 10; i++) begin
      bus.cmd_valid = (i == 3);
      bus.cmd       = 2'b10;
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rsp", 32'({bus.rsp_q, bus.rsp_qn, bus.rsp_err}), 32'({hq, hqn, he}));
      check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("hold_pins", 32'({bus.s_n, bus.r_n}), 32'b11);
    end
    bus.cmd_valid = 1'b0;
    ack_rsp();
    check("hold_idle_pins", 32'({bus.s_n, bus.r_n}), 32'b11);
    check("hold_idle_busy", 32'(bus.busy), 32'd0);

    // Reset mid-pulse
    bus.cmd_valid = 1'b1;
    bus.cmd       = 2'b01;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_pulse_s_n", 32'(bus.s_n), 32'd0);
    rst = 1'b1;
    #1;
    check("arst_s_n", 32'(bus.s_n), 32'd1);
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_err_cnt", 32'(bus.err_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_rsp", 32'({bus.rsp_valid, bus.s_n, bus.r_n}), 32'b011);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
